alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the 16-bit single-cycle ALU: same opcode map and SZCV flags, generic WIDTH.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 58 +++++
 rtl/alu_pipe.sv | 119 +++++++++++
 tb/tb_alu_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag bit positions and multiplier FSM states shared by the ALU pipeline
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam int F_S = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
  typedef enum logic [1:0] {MS_IDLE, MS_MUL, MS_DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product per cycle (built only with ALU_MUL_EN)
`ifdef ALU_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ack,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  mul_state_t state, state_n;
  logic [SHW-1:0] cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MS_IDLE;
      cnt    <= '0;
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_n;
      if (state == MS_IDLE && start) begin
        p      <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
      end else if (state == MS_MUL) begin
        if (mplier[0]) p <= p + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      MS_IDLE: state_n = start ? MS_MUL : MS_IDLE;
      MS_MUL:  state_n = (cnt == LAST) ? MS_DONE : MS_MUL;
      MS_DONE: state_n = ack ? MS_IDLE : MS_DONE;
      default: state_n = MS_IDLE;
    endcase
  end
  assign busy = state == MS_MUL;
  assign done = state == MS_DONE;
endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU with SZCV flags; define ALU_MUL_EN for the iterative MUL on opcode 0111
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wen,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags
);
  logic s1_valid, s2_load, s1_adv, is_mul;
  logic [3:0] s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, res;
  logic [SHW-1:0] s1_d;
  logic [WIDTH:0] sum, diff, sll_ext, srl_ext, sra_ext;
  logic [2*WIDTH-1:0] rol_ext;
  logic c, v, wen;
  logic [3:0] f_n;
  assign sum     = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff    = {1'b0, s1_b} - {1'b0, s1_a};
  // Extended shifts leave the last bit shifted out in the spare bit, and 0 there when d==0
  assign sll_ext = {1'b0, s1_b} << s1_d;
  assign srl_ext = {s1_b, 1'b0} >> s1_d;
  assign sra_ext = $signed({s1_b, 1'b0}) >>> s1_d;
  assign rol_ext = {s1_b, s1_b} << s1_d;
  assign s2_load = !out_valid || out_ready;
`ifdef ALU_MUL_EN
  logic mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_p;
  assign is_mul = s1_op == OP_MUL;
  assign s1_adv = s1_valid && s2_load && (!is_mul || mul_done);
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(s1_valid && is_mul && !mul_busy && !mul_done),
    .ack  (s1_adv && is_mul),
    .a    (s1_a),
    .b    (s1_b),
    .busy (mul_busy),
    .done (mul_done),
    .p    (mul_p)
  );
`else
  assign is_mul = 1'b0;
  assign s1_adv = s1_valid && s2_load;
`endif
  // A MUL occupies S1 until its product moves on, which keeps the front end closed
  assign in_ready = !rst && (!s1_valid || (s1_adv && !is_mul));
  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    wen = 1'b0;
    case (s1_op)
      OP_ADD: begin res = sum[WIDTH-1:0]; c = sum[WIDTH]; wen = 1'b1; v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]); end
      OP_SUB, OP_CMP: begin res = diff[WIDTH-1:0]; c = diff[WIDTH]; wen = s1_op == OP_SUB; v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_b[WIDTH-1]); end
      OP_AND: begin res = s1_a & s1_b; wen = 1'b1; end
      OP_OR:  begin res = s1_a | s1_b; wen = 1'b1; end
      OP_XOR: begin res = s1_a ^ s1_b; wen = 1'b1; end
      OP_MOV: begin res = s1_a; wen = 1'b1; end
`ifdef ALU_MUL_EN
      OP_MUL: begin res = mul_p[WIDTH-1:0]; c = |mul_p[2*WIDTH-1:WIDTH]; wen = 1'b1; end
`endif
      OP_SLL: begin res = sll_ext[WIDTH-1:0]; c = sll_ext[WIDTH]; wen = 1'b1; end
      OP_ROL: begin res = rol_ext[2*WIDTH-1:WIDTH]; wen = 1'b1; end
      OP_SRL: begin res = srl_ext[WIDTH:1]; c = srl_ext[0]; wen = 1'b1; end
      OP_SRA: begin res = sra_ext[WIDTH:1]; c = sra_ext[0]; wen = 1'b1; end
      default: res = '0;
    endcase
    f_n      = '0;
    f_n[F_S] = res[WIDTH-1];
    f_n[F_Z] = res == '0;
    f_n[F_C] = c;
    f_n[F_V] = v;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_d      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wen   <= 1'b0;
      out_flags <= '0;
      flags     <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_op    <= opcode;
        s1_a     <= a;
        s1_b     <= b;
        s1_d     <= d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) out_valid <= s1_adv;
      if (s1_adv) begin
        out_data  <= res;
        out_wen   <= wen;
        out_flags <= f_n;
      end
      if (out_valid && out_ready) flags <= out_flags;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=16
module tb_alu_pipe;
  import alu_pkg::*;
  localparam int W = 16;
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   d;
    logic [W-1:0] r;
    logic         w;
    logic [3:0]   f;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_wen;
  logic [3:0] opcode = '0;
  logic [3:0] out_flags, flags;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] out_data;
  logic [3:0] d = '0;
  int checks = 0;
  int errors = 0;
  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_wen(out_wen), .out_flags(out_flags), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [3:0] xd,
                       output logic [W-1:0] r, output logic w, output logic [3:0] f, output int lat, output int stall);
    @(negedge clk);
    opcode = op; a = xa; b = xb; d = xd; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0; stall = 0; r = '0; w = 1'b0; f = '0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
      if (out_valid) begin r = out_data; w = out_wen; f = out_flags; break; end
      if (!in_ready) stall++;
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== '0 || out_wen !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b want 0000/0", out_data, out_wen); end
    checks++; if (out_flags !== 4'h0 || flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b/%b want 0000/0000", out_flags, flags); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_add;
    logic [W-1:0] r; logic w; logic [3:0] f; int lat, st;
    do_op(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, r, w, f, lat, st);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL add_data got %h want 8000", r); end
    checks++; if (f !== 4'b1001) begin errors++; $display("FAIL add_flags got %b want 1001", f); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL add_wen got %b want 1", w); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_flagreg got %b want 1001", flags); end
  endtask
  task automatic test_cmp;
    logic [W-1:0] r; logic w; logic [3:0] f; int lat, st;
    do_op(OP_CMP, 16'h0005, 16'h0003, 4'd0, r, w, f, lat, st);
    checks++; if (r !== 16'hFFFE) begin errors++; $display("FAIL cmp_data got %h want fffe", r); end
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL cmp_wen got %b want 0", w); end
    checks++; if (f !== 4'b1010) begin errors++; $display("FAIL cmp_flags got %b want 1010", f); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL cmp_flagreg got %b want 1010", flags); end
  endtask
  task automatic test_ops;
    vec_t v [16];
    logic [W-1:0] r; logic w; logic [3:0] f; int lat, st;
    v = '{
      '{OP_SUB, 16'h0003, 16'h0005, 4'd0,  16'h0002, 1'b1, 4'b0000},
      '{OP_SUB, 16'h8000, 16'h0001, 4'd0,  16'h8001, 1'b1, 4'b1011},
      '{OP_ADD, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 4'b0110},
      '{OP_AND, 16'hF0F0, 16'hFF00, 4'd0,  16'hF000, 1'b1, 4'b1000},
      '{OP_OR,  16'h00F0, 16'h0F00, 4'd0,  16'h0FF0, 1'b1, 4'b0000},
      '{OP_XOR, 16'h1234, 16'h1234, 4'd0,  16'h0000, 1'b1, 4'b0100},
      '{OP_MOV, 16'h8000, 16'h5555, 4'd0,  16'h8000, 1'b1, 4'b1000},
      '{OP_SLL, 16'h0000, 16'h8001, 4'd1,  16'h0002, 1'b1, 4'b0010},
      '{OP_SLL, 16'h0000, 16'h8001, 4'd0,  16'h8001, 1'b1, 4'b1000},
      '{OP_ROL, 16'h0000, 16'h8001, 4'd4,  16'h0018, 1'b1, 4'b0000},
      '{OP_SRL, 16'h0000, 16'h1234, 4'd0,  16'h1234, 1'b1, 4'b0000},
      '{OP_SRL, 16'h0000, 16'h8000, 4'd15, 16'h0001, 1'b1, 4'b0000},
      '{OP_SRA, 16'h0000, 16'h8001, 4'd1,  16'hC000, 1'b1, 4'b1010},
      '{OP_SRA, 16'h0000, 16'h8000, 4'd15, 16'hFFFF, 1'b1, 4'b1000},
      '{4'b1110, 16'h1234, 16'h5678, 4'd0, 16'h0000, 1'b0, 4'b0100},
      '{4'b1111, 16'hFFFF, 16'hFFFF, 4'd3, 16'h0000, 1'b0, 4'b0100}
    };
    for (int i = 0; i < 16; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].d, r, w, f, lat, st);
      checks++; if (r !== v[i].r) begin errors++; $display("FAIL op%0d_data op=%b got %h want %h", i, v[i].op, r, v[i].r); end
      checks++; if (w !== v[i].w) begin errors++; $display("FAIL op%0d_wen op=%b got %b want %b", i, v[i].op, w, v[i].w); end
      checks++; if (f !== v[i].f) begin errors++; $display("FAIL op%0d_flags op=%b got %b want %b", i, v[i].op, f, v[i].f); end
      checks++; if (flags !== v[i].f) begin errors++; $display("FAIL op%0d_flagreg op=%b got %b want %b", i, v[i].op, flags, v[i].f); end
    end
  endtask
  task automatic test_back_to_back;
    int sent = 0, got = 0, cyc = 0, extra = 0;
    bit stalled = 0;
    logic fi;
    logic [W-1:0] exp_d;
    while ((sent < 8 || got < 8) && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 2) == 0;
      in_valid = sent < 8;
      opcode = OP_ADD; a = W'(sent + 1); b = W'((sent + 1) << 8); d = '0;
      #1;
      fi = in_valid && in_ready;
      if (in_valid && !in_ready) stalled = 1;
      if (out_valid && out_ready) begin
        exp_d = W'((got + 1) * 16'h0101);
        checks++; if (out_data !== exp_d || out_wen !== 1'b1) begin errors++; $display("FAIL b2b_result%0d got %h/%b want %h/1", got, out_data, out_wen, exp_d); end
        got++;
      end
      @(posedge clk);
      if (fi) sent++;
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
    checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop got %b want 1", stalled); end
    repeat (5) begin @(posedge clk); #1; if (out_valid) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_duplicates got %0d want 0", extra); end
  endtask
  task automatic test_async_reset;
    logic [W-1:0] r; logic w; logic [3:0] f; int lat, st, seen;
    do_op(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, r, w, f, lat, st);
    @(negedge clk);
    out_ready = 1'b0; opcode = OP_ADD; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state got valid=%b ready=%b want 1/0", out_valid, in_ready); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL pre_rst_flagreg got %b want 1001", flags); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_wen !== 1'b0) begin errors++; $display("FAIL async_rst_out got %b/%h/%b want 0/0000/0", out_valid, out_data, out_wen); end
    checks++; if (out_flags !== 4'h0 || flags !== 4'h0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b/%b ready=%b want 0000/0000/0", out_flags, flags, in_ready); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL async_rst_flush got %0d outputs want 0", seen); end
  endtask
`ifdef ALU_MUL_EN
  task automatic test_mul;
    logic [W-1:0] r; logic w; logic [3:0] f; int lat, st, seen;
    do_op(OP_MUL, 16'h0100, 16'h0100, 4'd0, r, w, f, lat, st);
    checks++; if (r !== 16'h0000 || w !== 1'b1) begin errors++; $display("FAIL mul_big got %h/%b want 0000/1", r, w); end
    checks++; if (f !== 4'b0110) begin errors++; $display("FAIL mul_big_flags got %b want 0110", f); end
    checks++; if (st < W || lat >= 100) begin errors++; $display("FAIL mul_stall got %0d lat %0d want >=%0d", st, lat, W); end
    do_op(OP_MUL, 16'h0003, 16'h0005, 4'd0, r, w, f, lat, st);
    checks++; if (r !== 16'h000F || f !== 4'b0000) begin errors++; $display("FAIL mul_small got %h/%b want 000f/0000", r, f); end
    @(negedge clk);
    opcode = OP_MUL; a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0 || in_ready !== 1'b1) begin errors++; $display("FAIL mul_abort got %0d outputs ready=%b want 0/1", seen, in_ready); end
  endtask
`else
  task automatic test_reserved;
    logic [W-1:0] r; logic w; logic [3:0] f; int lat, st;
    do_op(OP_MUL, 16'h0003, 16'h0005, 4'd0, r, w, f, lat, st);
    checks++; if (r !== 16'h0000 || w !== 1'b0 || f !== 4'b0100) begin errors++; $display("FAIL reserved got %h/%b/%b want 0000/0/0100", r, w, f); end
  endtask
`endif
  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_ops();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
`else
    test_reserved();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
